// File: rtl/vga_fill_arbiter_pkg.sv
// Shared constants, register map, fill state encoding and frame buffer
// address packing for the fill arbiter.
package vga_fill_arbiter_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   // register offsets from the block base address
   localparam logic [2:0] REG_X0     = 3'd0;
   localparam logic [2:0] REG_Y0     = 3'd1;
   localparam logic [2:0] REG_W      = 3'd2;
   localparam logic [2:0] REG_H      = 3'd3;
   localparam logic [2:0] REG_COLOUR = 3'd4;
   localparam logic [2:0] REG_CMD    = 3'd5;

   // CMD register bit positions
   localparam int CMD_START = 0;
   localparam int CMD_ABORT = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_e;

   function automatic logic [14:0] fb_pack(input logic [6:0] y, input logic [7:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/vga_fill_arbiter_walker.sv
// Rectangle walker: snapshots the fill geometry at start, clips it to the
// screen and steps row-major through the pixels, one step per fill grant.
module vga_fill_arbiter_walker #(
   parameter int SCREEN_W = vga_fill_arbiter_pkg::SCREEN_W,
   parameter int SCREEN_H = vga_fill_arbiter_pkg::SCREEN_H
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       load,
   input  logic       advance,
   input  logic [7:0] x0,
   input  logic [7:0] y0,
   input  logic [7:0] w,
   input  logic [7:0] h,
   output logic       empty,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic       last
);

   logic [7:0] x_start;
   logic [7:0] x_end;
   logic [6:0] y_end;
   logic [8:0] x_sum;
   logic [8:0] y_sum;
   logic [7:0] x_end_clip;
   logic [6:0] y_end_clip;

   // A fill with no area or an origin off screen writes nothing.
   assign empty = (w == 8'd0) || (h == 8'd0) ||
                  (x0 >= 8'(SCREEN_W)) || (y0 >= 8'(SCREEN_H));

   // 9-bit end coordinates so X0+W-1 cannot wrap before clipping.
   always_comb begin
      x_sum      = {1'b0, x0} + {1'b0, w} - 9'd1;
      y_sum      = {1'b0, y0} + {1'b0, h} - 9'd1;
      x_end_clip = (x_sum > 9'(SCREEN_W - 1)) ? 8'(SCREEN_W - 1) : x_sum[7:0];
      y_end_clip = (y_sum > 9'(SCREEN_H - 1)) ? 7'(SCREEN_H - 1) : y_sum[6:0];
   end

   // Snapshot on load, then raster-step on each fill grant.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         x_start <= '0;
         x_end   <= '0;
         y_end   <= '0;
         x       <= '0;
         y       <= '0;
      end else if (load) begin
         x_start <= x0;
         x_end   <= x_end_clip;
         y_end   <= y_end_clip;
         x       <= x0;
         y       <= y0[6:0];
      end else if (advance) begin
         if (x == x_end) begin
            x <= x_start;
            y <= y + 7'd1;
         end else begin
            x <= x + 8'd1;
         end
      end
   end

   assign last = (x == x_end) && (y == y_end);

endmodule

// File: rtl/vga_fill_arbiter.sv
// Frame buffer write-port owner: arbitrates the single-pixel path against
// the rectangle-fill engine and registers the winning write.
//
// state | meaning
// IDLE  | no fill running; pixel path owns every slot
// FILL  | fill engine walking the rectangle, sharing slots with the pixel path
// DONE  | fill finished; DONE_IRQ asserted for this one cycle
module vga_fill_arbiter #(
   parameter logic [7:0] BASE_ADDR     = 8'hC0,
   parameter int         SCREEN_W      = vga_fill_arbiter_pkg::SCREEN_W,
   parameter int         SCREEN_H      = vga_fill_arbiter_pkg::SCREEN_H,
   parameter int         MAX_PIX_BURST = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  ADDR,
   input  logic [7:0]  DATA,
   input  logic        BUS_WE,
   input  logic        PIX_REQ,
   input  logic [14:0] PIX_ADDR,
   input  logic [7:0]  PIX_DATA,
   output logic        PIX_ACK,
   output logic [14:0] FB_ADDR,
   output logic [7:0]  FB_DATA,
   output logic        FB_WE,
   output logic        BUSY,
   output logic        DONE_IRQ
);

   import vga_fill_arbiter_pkg::*;

   localparam int CNT_W = $clog2(MAX_PIX_BURST + 1);

   fill_state_e      state;
   fill_state_e      state_nxt;
   logic [7:0]       x0_r;
   logic [7:0]       y0_r;
   logic [7:0]       w_r;
   logic [7:0]       h_r;
   logic [7:0]       colour_r;
   logic [7:0]       fill_colour;
   logic [CNT_W-1:0] burst_cnt;
   logic [7:0]       reg_off;
   logic             reg_hit;
   logic             cmd_wr;
   logic             start_cmd;
   logic             abort_cmd;
   logic             fill_pend;
   logic             pix_grant;
   logic             fill_grant;
   logic             walk_load;
   logic             walk_empty;
   logic             walk_last;
   logic [7:0]       walk_x;
   logic [6:0]       walk_y;

   // Bus address decode; abort takes precedence over start in CMD.
   always_comb begin
      reg_off   = ADDR - BASE_ADDR;
      reg_hit   = BUS_WE && (reg_off < 8'd6);
      cmd_wr    = reg_hit && (reg_off[2:0] == REG_CMD);
      start_cmd = cmd_wr && DATA[CMD_START] && !DATA[CMD_ABORT];
      abort_cmd = cmd_wr && DATA[CMD_ABORT];
   end

   // Geometry/colour registers; always writable, the walker keeps its own copy.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         x0_r     <= '0;
         y0_r     <= '0;
         w_r      <= '0;
         h_r      <= '0;
         colour_r <= '0;
      end else if (reg_hit) begin
         case (reg_off[2:0])
            REG_X0:     x0_r     <= DATA;
            REG_Y0:     y0_r     <= DATA;
            REG_W:      w_r      <= DATA;
            REG_H:      h_r      <= DATA;
            REG_COLOUR: colour_r <= DATA;
            default:    ;
         endcase
      end
   end

   assign walk_load = (state == IDLE) && start_cmd && !walk_empty;

   vga_fill_arbiter_walker #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_walker (
      .CLK     (CLK),
      .RESET   (RESET),
      .load    (walk_load),
      .advance (fill_grant),
      .x0      (x0_r),
      .y0      (y0_r),
      .w       (w_r),
      .h       (h_r),
      .empty   (walk_empty),
      .x       (walk_x),
      .y       (walk_y),
      .last    (walk_last)
   );

   // Colour snapshot so COLOUR rewrites do not disturb a running fill.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         fill_colour <= '0;
      end else if (walk_load) begin
         fill_colour <= colour_r;
      end
   end

   // One grant per cycle; the fill steals the slot after a full pixel burst.
   // An abort cycle issues no fill grant. Grants are held off during reset.
   always_comb begin
      fill_pend  = (state == FILL) && !abort_cmd;
      pix_grant  = 1'b0;
      fill_grant = 1'b0;
      if (RESET) begin
         if (fill_pend && (burst_cnt == CNT_W'(MAX_PIX_BURST))) begin
            fill_grant = 1'b1;
         end else if (PIX_REQ) begin
            pix_grant = 1'b1;
         end else if (fill_pend) begin
            fill_grant = 1'b1;
         end
      end
   end

   assign PIX_ACK = pix_grant;

   // Burst counter: pixel grants made during FILL since the last fill grant.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         burst_cnt <= '0;
      end else if ((state != FILL) || fill_grant) begin
         burst_cnt <= '0;
      end else if (pix_grant && (burst_cnt != CNT_W'(MAX_PIX_BURST))) begin
         burst_cnt <= burst_cnt + CNT_W'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; starts outside IDLE are ignored.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_cmd) state_nxt = walk_empty ? DONE : FILL;
         FILL: begin
            if (abort_cmd) begin
               state_nxt = IDLE;
            end else if (fill_grant && walk_last) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      BUSY     = (state == FILL);
      DONE_IRQ = (state == DONE);
   end

   // Registered frame buffer write, one cycle after the grant.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         FB_WE   <= 1'b0;
         FB_ADDR <= '0;
         FB_DATA <= '0;
      end else begin
         FB_WE <= pix_grant || fill_grant;
         if (fill_grant) begin
            FB_ADDR <= fb_pack(walk_y, walk_x);
            FB_DATA <= fill_colour;
         end else if (pix_grant) begin
            FB_ADDR <= PIX_ADDR;
            FB_DATA <= PIX_DATA;
         end
      end
   end

endmodule
